// File: rtl/conv_sequencer_if.sv
// Handshake and bus bundle for conv_sequencer: frame control, pixel stream,
// kernel write port and result stream.
interface conv_sequencer_if #(
  parameter int DW    = 16,
  parameter int IDX_W = 6
);
  logic          start;
  logic          busy;
  logic          done;
  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] pix_data;
  logic          w_we;
  logic [3:0]    w_addr;
  logic [DW-1:0] w_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IDX_W-1:0] out_idx;

  modport master (
    output start, pix_valid, pix_data, w_we, w_addr, w_data, out_ready,
    input  busy, done, pix_ready, out_valid, out_data, out_idx
  );

  modport slave (
    input  start, pix_valid, pix_data, w_we, w_addr, w_data, out_ready,
    output busy, done, pix_ready, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/conv_sequencer.sv
// Time-multiplexed 3x3 convolution sequencer over a buffered 6x6 map, one MAC tap per cycle.
// Optional macro SAT_EN: saturate results to DW bits instead of wrapping.
module conv_sequencer #(
  parameter int DW    = 16,
  parameter int IMG   = 6,
  parameter int K     = 3,
  parameter int ACC_W = 36
) (
  input  logic clk,
  input  logic rst_n,
  conv_sequencer_if.slave bus
);

  localparam int NPIX = IMG * IMG;
  localparam int NTAP = K * K;
  localparam int IW   = $clog2(NPIX);
  localparam int CW   = $clog2(IMG);
  localparam int KW   = $clog2(K);
  localparam int TW   = $clog2(NTAP);
  localparam int PW   = 2 * DW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DW-1:0]    r_buf [NPIX];
  logic [DW-1:0]    r_kern [NTAP];
  logic [IW-1:0]    r_cnt;
  logic [CW-1:0]    r_i;
  logic [CW-1:0]    r_j;
  logic [KW-1:0]    r_m;
  logic [KW-1:0]    r_n;
  logic [ACC_W-1:0] r_acc_p1;
  logic [DW-1:0]    r_out_data_p1;
  logic [IW-1:0]    r_out_idx_p1;

  logic             w_last_beat;
  logic             w_last_tap;
  logic             w_last_pos;
  logic [CW:0]      w_row;
  logic [CW:0]      w_col;
  logic             w_skip;
  logic [TW-1:0]    w_tap;
  logic [IW-1:0]    w_baddr;
  logic [PW-1:0]    w_prod_p0;
  logic [ACC_W-1:0] w_acc_base;
  logic [ACC_W-1:0] w_acc_nxt;

  function automatic logic [DW-1:0] f_out(input logic [ACC_W-1:0] a);
`ifdef SAT_EN
    f_out = (a > ACC_W'({DW{1'b1}})) ? {DW{1'b1}} : a[DW-1:0];
`else
    f_out = a[DW-1:0];
`endif
  endfunction

  assign w_last_beat = (r_state == S_LOAD) && bus.pix_valid && (r_cnt == IW'(NPIX - 1));
  assign w_last_tap  = (r_m == KW'(K - 1)) && (r_n == KW'(K - 1));
  assign w_last_pos  = (r_i == CW'(IMG - 1)) && (r_j == CW'(IMG - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.pix_ready = 1'b0;
    bus.out_valid = 1'b0;
    unique case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        bus.busy      = 1'b1;
        bus.pix_ready = 1'b1;
        if (w_last_beat) w_state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        bus.busy = 1'b1;
        if (w_last_tap) w_state_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = w_last_pos ? S_DONE : S_COMPUTE;
      end
      S_DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: tap address, border skip and full-width product
  always_comb begin
    w_row      = {1'b0, r_i} + (CW + 1)'(r_m);
    w_col      = {1'b0, r_j} + (CW + 1)'(r_n);
    w_skip     = (32'(w_row) >= IMG) || (32'(w_col) >= IMG);
    w_tap      = TW'(32'(r_m) * K + 32'(r_n));
    w_baddr    = w_skip ? '0 : IW'(32'(w_row) * IMG + 32'(w_col));
    w_prod_p0  = PW'(r_buf[w_baddr]) * PW'(r_kern[w_tap]);
    w_acc_base = (r_m == '0 && r_n == '0) ? '0 : r_acc_p1;
    w_acc_nxt  = w_acc_base + (w_skip ? '0 : ACC_W'(w_prod_p0));
  end

  // Stage p1: accumulator, pixel buffer (data only, never reset)
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && bus.pix_valid) r_buf[r_cnt] <= bus.pix_data;
    if (r_state == S_COMPUTE) r_acc_p1 <= w_acc_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_i           <= '0;
      r_j           <= '0;
      r_m           <= '0;
      r_n           <= '0;
      r_out_data_p1 <= '0;
      r_out_idx_p1  <= '0;
      for (int t = 0; t < NTAP; t++) r_kern[t] <= DW'(1);
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.w_we && (32'(bus.w_addr) < NTAP)) r_kern[bus.w_addr] <= bus.w_data;
          if (bus.start) r_cnt <= '0;
        end
        S_LOAD: begin
          if (bus.pix_valid) r_cnt <= r_cnt + 1'b1;
          if (w_last_beat) begin
            r_i <= '0;
            r_j <= '0;
            r_m <= '0;
            r_n <= '0;
          end
        end
        S_COMPUTE: begin
          if (r_n == KW'(K - 1)) begin
            r_n <= '0;
            r_m <= r_m + 1'b1;
          end else begin
            r_n <= r_n + 1'b1;
          end
          // Result registered at the final tap so OUTPUT presents it with no extra cycle
          if (w_last_tap) begin
            r_m           <= '0;
            r_out_data_p1 <= f_out(w_acc_nxt);
            r_out_idx_p1  <= IW'(32'(r_i) * IMG + 32'(r_j));
          end
        end
        S_OUTPUT: begin
          if (bus.out_ready && !w_last_pos) begin
            if (r_j == CW'(IMG - 1)) begin
              r_j <= '0;
              r_i <= r_i + 1'b1;
            end else begin
              r_j <= r_j + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_data = r_out_data_p1;
  assign bus.out_idx  = r_out_idx_p1;

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: randomized frames against a direct
// convolution model, plus timing, stall, reset and back-to-back scenarios.
module tb_conv_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [15:0] tb_pix [36];
  logic [15:0] tb_kern [9];
  logic [15:0] exp_q [36];
  logic [15:0] got [36];
  int order [36];
  int hs_cyc [36];
  int valid_cyc [36];
  bit seen [36];
  int nres, beat_cyc, load0_cyc, done_cyc;
  bit hold_bad, timeout;

  conv_sequencer_if #(.DW(16), .IDX_W(6)) ifc ();

  conv_sequencer #(.DW(16), .IMG(6), .K(3), .ACC_W(36)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_frame();
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        longint unsigned acc;
        acc = 0;
        for (int m = 0; m < 3; m++)
          for (int n = 0; n < 3; n++)
            if (i + m < 6 && j + n < 6)
              acc += longint'(tb_pix[(i + m) * 6 + j + n]) * longint'(tb_kern[m * 3 + n]);
`ifdef SAT_EN
        exp_q[i * 6 + j] = (acc > 65535) ? 16'hFFFF : acc[15:0];
`else
        exp_q[i * 6 + j] = acc[15:0];
`endif
      end
    end
  endtask

  task automatic write_kern(input logic [3:0] a, input logic [15:0] d);
    ifc.w_we = 1'b1; ifc.w_addr = a; ifc.w_data = d;
    if (a < 9) tb_kern[a] = d;
    step();
    ifc.w_we = 1'b0;
  endtask

  task automatic kick(input bit we, input logic [3:0] a, input logic [15:0] d);
    ifc.start = 1'b1; ifc.w_we = we; ifc.w_addr = a; ifc.w_data = d;
    if (we && a < 9) tb_kern[a] = d;
    step();
    ifc.start = 1'b0; ifc.w_we = 1'b0;
  endtask

  // Drives one frame from the LOAD state; returns in the DONE cycle or once abort_at results are taken.
  task automatic run_frame(input int gap_pct, input int stall_pct, input int hold_idx,
                           input bit noise, input int abort_at);
    int k, hold, guard;
    logic [15:0] hd;
    logic [5:0] hi;
    bit rdy, v;
    k = 0; hold = 0; guard = 0; nres = 0; hold_bad = 0; timeout = 0;
    done_cyc = -1; beat_cyc = -1; load0_cyc = -1; hd = '0; hi = '0;
    for (int q = 0; q < 36; q++) begin seen[q] = 0; valid_cyc[q] = -1; hs_cyc[q] = -1; order[q] = -1; end
    while (1) begin
      if (ifc.done) begin done_cyc = cyc; break; end
      if (nres == abort_at) break;
      if (guard >= 5000) begin timeout = 1; break; end
      if (hold > 0 && hold < 7 && !ifc.out_valid) hold_bad = 1;
      rdy = 0;
      if (ifc.out_valid) begin
        if (!seen[ifc.out_idx]) begin seen[ifc.out_idx] = 1; valid_cyc[ifc.out_idx] = cyc; end
        if (int'(ifc.out_idx) == hold_idx && hold < 7) begin
          if (hold == 0) begin hd = ifc.out_data; hi = ifc.out_idx; end
          else if (ifc.out_data !== hd || ifc.out_idx !== hi) hold_bad = 1;
          hold++;
        end else begin
          rdy = ($urandom_range(99) >= stall_pct);
        end
        if (rdy && ifc.out_idx < 36 && nres < 36) begin
          got[ifc.out_idx] = ifc.out_data;
          order[nres] = int'(ifc.out_idx);
          hs_cyc[nres] = cyc;
          nres++;
        end
      end
      ifc.out_ready = rdy;
      if (ifc.pix_ready && k < 36) begin
        v = ($urandom_range(99) >= gap_pct);
        ifc.pix_valid = v;
        ifc.pix_data = v ? tb_pix[k] : 16'($urandom);
        if (v) begin
          if (k == 0) load0_cyc = cyc;
          if (k == 35) beat_cyc = cyc;
          k++;
        end
      end else begin
        ifc.pix_valid = 1'b0;
      end
      if (noise && ifc.busy) begin
        ifc.w_we = 1'($urandom_range(1)); ifc.w_addr = 4'($urandom_range(15));
        ifc.w_data = 16'($urandom); ifc.start = 1'($urandom_range(1));
      end else begin
        ifc.w_we = 1'b0; ifc.start = 1'b0;
      end
      step();
      guard++;
    end
    ifc.pix_valid = 1'b0; ifc.out_ready = 1'b0; ifc.w_we = 1'b0; ifc.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_cmp++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", ifc.busy); end
    n_cmp++; if (ifc.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", ifc.done); end
    n_cmp++; if (ifc.pix_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pix_ready: got %b want 0", ifc.pix_ready); end
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
    n_cmp++; if (ifc.out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", ifc.out_data); end
    n_cmp++; if (ifc.out_idx !== 6'h0) begin n_fail++; $display("FAIL reset_out_idx: got %0d want 0", ifc.out_idx); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ones_timing();
    int bad;
    for (int q = 0; q < 36; q++) tb_pix[q] = 16'd1;
    for (int t = 0; t < 9; t++) tb_kern[t] = 16'd1;
    kick(0, 4'd0, 16'd0);
    run_frame(0, 0, -1, 0, -1);
    model_frame();
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL ones_timeout: got %b want 0", timeout); end
    n_cmp++; if (got[0] !== 16'd9) begin n_fail++; $display("FAIL ones_out0: got %0d want 9", got[0]); end
    n_cmp++; if (got[5] !== 16'd3) begin n_fail++; $display("FAIL ones_out5: got %0d want 3", got[5]); end
    n_cmp++; if (got[30] !== 16'd3) begin n_fail++; $display("FAIL ones_out30: got %0d want 3", got[30]); end
    n_cmp++; if (got[34] !== 16'd2) begin n_fail++; $display("FAIL ones_out34: got %0d want 2", got[34]); end
    n_cmp++; if (got[35] !== 16'd1) begin n_fail++; $display("FAIL ones_out35: got %0d want 1", got[35]); end
    for (int q = 0; q < 36; q++) begin
      n_cmp++; if (got[q] !== exp_q[q]) begin n_fail++; $display("FAIL ones_model[%0d]: got %0d want %0d", q, got[q], exp_q[q]); end
      n_cmp++; if (order[q] != q) begin n_fail++; $display("FAIL ones_order[%0d]: got %0d want %0d", q, order[q], q); end
    end
    n_cmp++; if (valid_cyc[0] - beat_cyc != 10) begin n_fail++; $display("FAIL first_latency: got %0d want 10", valid_cyc[0] - beat_cyc); end
    bad = 0;
    for (int q = 1; q < 36; q++) if (valid_cyc[q] - valid_cyc[q-1] != 10) bad++;
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL result_spacing: got %0d bad gaps want 0", bad); end
    n_cmp++; if (done_cyc - load0_cyc != 396) begin n_fail++; $display("FAIL frame_length: got %0d want 396", done_cyc - load0_cyc); end
    n_cmp++; if (done_cyc - hs_cyc[35] != 1) begin n_fail++; $display("FAIL done_after_last: got %0d want 1", done_cyc - hs_cyc[35]); end
    step();
    n_cmp++; if (ifc.done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b want 0", ifc.done); end
    n_cmp++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", ifc.busy); end
  endtask

  task automatic test_ramp();
    for (int q = 0; q < 36; q++) tb_pix[q] = 16'(q);
    kick(0, 4'd0, 16'd0);
    run_frame(0, 30, -1, 0, -1);
    model_frame();
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL ramp_timeout: got %b want 0", timeout); end
    n_cmp++; if (got[0] !== 16'd63) begin n_fail++; $display("FAIL ramp_out0: got %0d want 63", got[0]); end
    n_cmp++; if (got[35] !== 16'd35) begin n_fail++; $display("FAIL ramp_out35: got %0d want 35", got[35]); end
    n_cmp++; if (got[28] !== 16'd126) begin n_fail++; $display("FAIL ramp_out28: got %0d want 126", got[28]); end
    for (int q = 0; q < 36; q++) begin
      n_cmp++; if (got[q] !== exp_q[q]) begin n_fail++; $display("FAIL ramp_model[%0d]: got %0d want %0d", q, got[q], exp_q[q]); end
    end
    step();
  endtask

  task automatic test_kernel_write();
    for (int t = 0; t < 9; t++) if (t != 4) write_kern(4'(t), 16'd0);
    for (int a = 9; a < 16; a++) write_kern(4'(a), 16'($urandom));
    for (int q = 0; q < 36; q++) tb_pix[q] = 16'd5;
    kick(1, 4'd4, 16'd2);
    run_frame(0, 0, -1, 1, -1);
    model_frame();
    n_cmp++; if (got[0] !== 16'd10) begin n_fail++; $display("FAIL kern_out0: got %0d want 10", got[0]); end
    n_cmp++; if (got[14] !== 16'd10) begin n_fail++; $display("FAIL kern_out14: got %0d want 10", got[14]); end
    for (int q = 0; q < 36; q++) begin
      n_cmp++; if (got[q] !== exp_q[q]) begin n_fail++; $display("FAIL kern_model[%0d]: got %0d want %0d", q, got[q], exp_q[q]); end
    end
    step();
    kick(0, 4'd0, 16'd0);
    run_frame(0, 0, -1, 0, -1);
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL kern_timeout: got %b want 0", timeout); end
    for (int q = 0; q < 36; q++) begin
      n_cmp++; if (got[q] !== exp_q[q]) begin n_fail++; $display("FAIL kern_kept[%0d]: got %0d want %0d", q, got[q], exp_q[q]); end
    end
    step();
  endtask

  task automatic test_stall_gaps();
    for (int q = 0; q < 36; q++) tb_pix[q] = 16'($urandom);
    for (int t = 0; t < 9; t++) write_kern(4'(t), 16'($urandom));
    kick(0, 4'd0, 16'd0);
    run_frame(40, 30, 3, 0, -1);
    model_frame();
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: got %b want 0", timeout); end
    n_cmp++; if (hold_bad !== 1'b0) begin n_fail++; $display("FAIL stall_hold: got %b want 0", hold_bad); end
    n_cmp++; if (valid_cyc[4] - hs_cyc[3] != 10) begin n_fail++; $display("FAIL stall_resume: got %0d want 10", valid_cyc[4] - hs_cyc[3]); end
    for (int q = 0; q < 36; q++) begin
      n_cmp++; if (got[q] !== exp_q[q]) begin n_fail++; $display("FAIL stall_model[%0d]: got %0d want %0d", q, got[q], exp_q[q]); end
      n_cmp++; if (order[q] != q) begin n_fail++; $display("FAIL stall_order[%0d]: got %0d want %0d", q, order[q], q); end
    end
    step();
  endtask

  task automatic test_saturation();
    logic [15:0] want;
`ifdef SAT_EN
    want = 16'hFFFF;
`else
    want = 16'h0000;
`endif
    for (int q = 0; q < 36; q++) tb_pix[q] = 16'h1000;
    for (int t = 0; t < 9; t++) write_kern(4'(t), 16'h0010);
    kick(0, 4'd0, 16'd0);
    run_frame(0, 0, -1, 0, -1);
    model_frame();
    n_cmp++; if (got[0] !== want) begin n_fail++; $display("FAIL sat_out0: got %h want %h", got[0], want); end
    n_cmp++; if (got[35] !== want) begin n_fail++; $display("FAIL sat_out35: got %h want %h", got[35], want); end
    for (int q = 0; q < 36; q++) begin
      n_cmp++; if (got[q] !== exp_q[q]) begin n_fail++; $display("FAIL sat_model[%0d]: got %h want %h", q, got[q], exp_q[q]); end
    end
    step();
  endtask

  task automatic test_reset_mid();
    for (int q = 0; q < 36; q++) tb_pix[q] = 16'($urandom_range(65535, 1));
    kick(0, 4'd0, 16'd0);
    run_frame(0, 0, -1, 0, 17);
    step(); step(); step();
    n_cmp++; if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", ifc.busy); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", ifc.busy); end
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", ifc.out_valid); end
    n_cmp++; if (ifc.pix_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", ifc.pix_ready); end
    n_cmp++; if (ifc.done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got %b want 0", ifc.done); end
    n_cmp++; if (ifc.out_data !== 16'h0) begin n_fail++; $display("FAIL mid_rst_data: got %h want 0", ifc.out_data); end
    n_cmp++; if (ifc.out_idx !== 6'h0) begin n_fail++; $display("FAIL mid_rst_idx: got %0d want 0", ifc.out_idx); end
    for (int t = 0; t < 9; t++) tb_kern[t] = 16'd1;
    for (int q = 0; q < 36; q++) tb_pix[q] = 16'($urandom);
    kick(0, 4'd0, 16'd0);
    run_frame(10, 10, -1, 0, -1);
    model_frame();
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL mid_timeout: got %b want 0", timeout); end
    for (int q = 0; q < 36; q++) begin
      n_cmp++; if (got[q] !== exp_q[q]) begin n_fail++; $display("FAIL mid_model[%0d]: got %0d want %0d", q, got[q], exp_q[q]); end
    end
  endtask

  task automatic test_back_to_back();
    ifc.start = 1'b1;
    step();
    n_cmp++; if (ifc.pix_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", ifc.pix_ready); end
    step();
    ifc.start = 1'b0;
    n_cmp++; if (ifc.pix_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_load: got %b want 1", ifc.pix_ready); end
    for (int q = 0; q < 36; q++) tb_pix[q] = 16'($urandom);
    run_frame(20, 20, -1, 1, -1);
    model_frame();
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout: got %b want 0", timeout); end
    for (int q = 0; q < 36; q++) begin
      n_cmp++; if (got[q] !== exp_q[q]) begin n_fail++; $display("FAIL b2b_model[%0d]: got %0d want %0d", q, got[q], exp_q[q]); end
    end
    step();
  endtask

  initial begin
    ifc.start = 1'b0; ifc.pix_valid = 1'b0; ifc.pix_data = '0;
    ifc.w_we = 1'b0; ifc.w_addr = '0; ifc.w_data = '0; ifc.out_ready = 1'b0;
    #1;
    test_reset();
    test_ones_timing();
    test_ramp();
    test_kernel_write();
    test_stall_gaps();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
